// File: rtl/br_ckpt_ctrl.sv
// Branch checkpoint controller: snapshots free-list head / ROB tail per dispatched
// branch, releases on correct resolve, and drives a one-cycle recovery on mispredict.
module br_ckpt_ctrl #(
   parameter int NUM_CKPT  = 4,
   parameter int TAG_W     = 2,
   parameter int FL_PTR_W  = 5,
   parameter int ROB_PTR_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dispatch_en_i,
   input  logic                 dispatch_is_br_i,
   input  logic [FL_PTR_W-1:0]  fl_head_i,
   input  logic [ROB_PTR_W-1:0] rob_tail_i,
   input  logic                 br_resolve_en_i,
   input  logic [TAG_W-1:0]     br_resolve_tag_i,
   input  logic                 br_mispredict_i,
   output logic                 br_stall_o,
   output logic                 dispatch_stall_o,
   output logic [TAG_W-1:0]     br_tag_o,
   output logic [NUM_CKPT-1:0]  br_mask_o,
   output logic                 fl_recover_en_o,
   output logic [FL_PTR_W-1:0]  fl_recover_head_o,
   output logic                 rob_recover_en_o,
   output logic [ROB_PTR_W-1:0] rob_recover_tail_o,
   output logic [NUM_CKPT-1:0]  squash_mask_o
);

   logic [NUM_CKPT-1:0]                valid, valid_nxt;
   logic [NUM_CKPT-1:0][FL_PTR_W-1:0]  fl_head;
   logic [NUM_CKPT-1:0][ROB_PTR_W-1:0] rob_tail;
   logic [NUM_CKPT-1:0][NUM_CKPT-1:0]  dep;
   logic                               rec_en;
   logic [FL_PTR_W-1:0]                rec_head;
   logic [ROB_PTR_W-1:0]               rec_tail;
   logic [NUM_CKPT-1:0]                rec_sq;

   logic                res_hit, res_ok, res_bad, alloc;
   logic [TAG_W-1:0]    alloc_idx;
   logic [NUM_CKPT-1:0] clr, kill;

   assign br_stall_o         = &valid;
   assign dispatch_stall_o   = rec_en;
   assign fl_recover_en_o    = rec_en;
   assign rob_recover_en_o   = rec_en;
   assign fl_recover_head_o  = rec_head;
   assign rob_recover_tail_o = rec_tail;
   assign squash_mask_o      = rec_sq;

   always_comb begin
      res_hit   = valid[br_resolve_tag_i];
      res_ok    = br_resolve_en_i & ~br_mispredict_i & res_hit;
      res_bad   = br_resolve_en_i &  br_mispredict_i & res_hit;
      alloc_idx = '0;
      clr       = '0;
      kill      = '0;
      // descending scan so the lowest free index is the one left standing
      for (int k = NUM_CKPT-1; k >= 0; k--)
         if (!valid[k]) alloc_idx = TAG_W'(k);
      for (int j = 0; j < NUM_CKPT; j++) begin
         clr[j]  = res_ok & (TAG_W'(j) == br_resolve_tag_i);
         kill[j] = res_bad & ((TAG_W'(j) == br_resolve_tag_i) |
                              (valid[j] & dep[j][br_resolve_tag_i]));
      end
      br_tag_o  = br_stall_o ? '0 : alloc_idx;
      br_mask_o = valid & ~clr;
      alloc     = dispatch_en_i & dispatch_is_br_i & ~br_stall_o & ~rec_en & ~res_bad;
      valid_nxt = valid & ~clr & ~kill;
      if (alloc) valid_nxt[alloc_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= '0;
         dep      <= '0;
         fl_head  <= '0;
         rob_tail <= '0;
         rec_en   <= 1'b0;
         rec_head <= '0;
         rec_tail <= '0;
         rec_sq   <= '0;
      end else begin
         valid  <= valid_nxt;
         rec_en <= res_bad;
         if (res_ok)
            for (int j = 0; j < NUM_CKPT; j++) dep[j][br_resolve_tag_i] <= 1'b0;
         if (alloc) begin
            fl_head[alloc_idx]  <= fl_head_i;
            rob_tail[alloc_idx] <= rob_tail_i;
            dep[alloc_idx]      <= br_mask_o;
         end
         if (res_bad) begin
            rec_head <= fl_head[br_resolve_tag_i];
            rec_tail <= rob_tail[br_resolve_tag_i];
            rec_sq   <= kill;
         end
      end
   end

endmodule

// File: tb/tb_br_ckpt_ctrl.sv
// Directed, table-driven bench for br_ckpt_ctrl: one row per cycle, inputs plus the
// outputs expected in that same cycle (sampled 1ns after the falling edge).
module tb_br_ckpt_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       dispatch_en_i, dispatch_is_br_i;
   logic [4:0] fl_head_i, rob_tail_i;
   logic       br_resolve_en_i;
   logic [1:0] br_resolve_tag_i;
   logic       br_mispredict_i;
   logic       br_stall_o, dispatch_stall_o;
   logic [1:0] br_tag_o;
   logic [3:0] br_mask_o;
   logic       fl_recover_en_o, rob_recover_en_o;
   logic [4:0] fl_recover_head_o, rob_recover_tail_o;
   logic [3:0] squash_mask_o;

   br_ckpt_ctrl #(.NUM_CKPT(4), .TAG_W(2), .FL_PTR_W(5), .ROB_PTR_W(5)) dut (
      .clk(clk), .rst(rst),
      .dispatch_en_i(dispatch_en_i), .dispatch_is_br_i(dispatch_is_br_i),
      .fl_head_i(fl_head_i), .rob_tail_i(rob_tail_i),
      .br_resolve_en_i(br_resolve_en_i), .br_resolve_tag_i(br_resolve_tag_i),
      .br_mispredict_i(br_mispredict_i),
      .br_stall_o(br_stall_o), .dispatch_stall_o(dispatch_stall_o),
      .br_tag_o(br_tag_o), .br_mask_o(br_mask_o),
      .fl_recover_en_o(fl_recover_en_o), .fl_recover_head_o(fl_recover_head_o),
      .rob_recover_en_o(rob_recover_en_o), .rob_recover_tail_o(rob_recover_tail_o),
      .squash_mask_o(squash_mask_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, de, br;
      logic [4:0] fl, rob;
      logic       re;
      logic [1:0] rt;
      logic       mp;
      logic       st, ds;
      logic [1:0] tg;
      logic [3:0] mk;
      logic       rc;
      logic [4:0] hd, tl;
      logic [3:0] sq;
      logic       cd;
   } vec_t;

   vec_t vq[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic add(input logic r, de, br, input logic [4:0] fl, rob,
                      input logic re, input logic [1:0] rt, input logic mp,
                      input logic st, ds, input logic [1:0] tg, input logic [3:0] mk,
                      input logic rc, input logic [4:0] hd, tl, input logic [3:0] sq,
                      input logic cd);
      vec_t v;
      v.rst = r; v.de = de; v.br = br; v.fl = fl; v.rob = rob;
      v.re = re; v.rt = rt; v.mp = mp;
      v.st = st; v.ds = ds; v.tg = tg; v.mk = mk;
      v.rc = rc; v.hd = hd; v.tl = tl; v.sq = sq; v.cd = cd;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s row %0d: got %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst = v.rst; dispatch_en_i = v.de; dispatch_is_br_i = v.br;
      fl_head_i = v.fl; rob_tail_i = v.rob;
      br_resolve_en_i = v.re; br_resolve_tag_i = v.rt; br_mispredict_i = v.mp;
   endtask

   initial begin
      vec_t idle;
      idle = '{default: '0};
      drive(idle);
      rst = 1'b1;
      // rst de br fl rob re rt mp | st ds tg mask rc hd tl sq cd
      add(0,0,0, 0, 0, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,1); // 0 reset state
      add(0,1,1, 3, 6, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,0); // 1
      add(0,1,1, 5,10, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,1,1, 7,14, 0,0,0, 0,0,2,4'b0011, 0, 0, 0,4'b0000,0);
      add(0,1,1, 9,18, 0,0,0, 0,0,3,4'b0111, 0, 0, 0,4'b0000,0);
      add(0,1,1,11,22, 0,0,0, 1,0,0,4'b1111, 0, 0, 0,4'b0000,0); // 5 full, no alloc
      add(0,0,0, 0, 0, 1,1,0, 1,0,0,4'b1101, 0, 0, 0,4'b0000,0); // correct tag1
      add(0,1,1,13,26, 0,0,0, 0,0,1,4'b1101, 0, 0, 0,4'b0000,0); // realloc tag1, dep 1101
      add(0,0,0, 0, 0, 1,2,1, 1,0,0,4'b1111, 0, 0, 0,4'b0000,0); // mispredict tag2
      add(0,0,0, 0, 0, 0,0,0, 0,1,1,4'b0001, 1, 7,14,4'b1110,0); // 9 kills 1,2,3
      add(0,0,0, 0, 0, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,1,1, 5,10, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,1,1, 7,14, 0,0,0, 0,0,2,4'b0011, 0, 0, 0,4'b0000,0);
      add(0,1,1, 9,18, 0,0,0, 0,0,3,4'b0111, 0, 0, 0,4'b0000,0);
      add(0,1,1,11,22, 1,1,1, 1,0,0,4'b1111, 0, 0, 0,4'b0000,0); // mispredict tag1
      add(0,1,1,20,20, 0,0,0, 0,1,1,4'b0001, 1, 5,10,4'b1110,0); // 15 dispatch dropped
      add(0,0,0, 0, 0, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,1,1, 5,10, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,1,1,21,22, 1,0,1, 0,0,2,4'b0011, 0, 0, 0,4'b0000,0); // mispredict tag0 + br
      add(0,0,0, 0, 0, 0,0,0, 0,1,0,4'b0000, 1, 3, 6,4'b0011,0); // 19
      add(0,0,0, 0, 0, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,0);
      add(0,1,1, 3, 6, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,0);
      add(0,1,1, 5,10, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,1,1, 7,14, 0,0,0, 0,0,2,4'b0011, 0, 0, 0,4'b0000,0);
      add(0,1,1, 9,18, 0,0,0, 0,0,3,4'b0111, 0, 0, 0,4'b0000,0);
      add(0,0,0, 0, 0, 1,2,1, 1,0,0,4'b1111, 0, 0, 0,4'b0000,0); // 25 mispredict tag2
      add(0,0,0, 0, 0, 1,3,1, 0,1,2,4'b0011, 1, 7,14,4'b1100,0); // squashed tag3 ignored
      add(0,0,0, 0, 0, 0,0,0, 0,0,2,4'b0011, 0, 0, 0,4'b0000,0); // no second pulse
      add(0,0,0, 0, 0, 1,1,1, 0,0,2,4'b0011, 0, 0, 0,4'b0000,0); // mispredict tag1
      add(0,0,0, 0, 0, 1,0,1, 0,1,1,4'b0001, 1, 5,10,4'b0010,0); // older tag0 mispredicts
      add(0,0,0, 0, 0, 0,0,0, 0,1,0,4'b0000, 1, 3, 6,4'b0001,0); // 30 back-to-back
      add(0,0,0, 0, 0, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,0);
      add(0,1,1,12,24, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,0);
      add(0,1,1,13,25, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,0,0, 0, 0, 1,1,1, 0,0,2,4'b0011, 0, 0, 0,4'b0000,0);
      add(1,0,0, 0, 0, 0,0,0, 0,1,1,4'b0001, 1,13,25,4'b0010,0); // 35 rst in recovery
      add(0,0,0, 0, 0, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,1); // all cleared
      add(0,1,1, 1, 2, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,0);
      add(0,1,1, 2, 3, 0,0,0, 0,0,1,4'b0001, 0, 0, 0,4'b0000,0);
      add(0,1,1, 4, 5, 1,0,0, 0,0,2,4'b0010, 0, 0, 0,4'b0000,0); // resolve + dispatch
      add(0,0,0, 0, 0, 1,1,1, 0,0,0,4'b0110, 0, 0, 0,4'b0000,0); // 40 mispredict tag1
      add(0,0,0, 0, 0, 0,0,0, 0,1,0,4'b0000, 1, 2, 3,4'b0110,0);
      add(0,0,0, 0, 0, 0,0,0, 0,0,0,4'b0000, 0, 0, 0,4'b0000,0);

      repeat (2) @(posedge clk);
      foreach (vq[i]) begin
         @(negedge clk);
         drive(vq[i]);
         #1;
         chk("br_stall", i, int'(br_stall_o), int'(vq[i].st));
         chk("dispatch_stall", i, int'(dispatch_stall_o), int'(vq[i].ds));
         chk("br_tag", i, int'(br_tag_o), int'(vq[i].tg));
         chk("br_mask", i, int'(br_mask_o), int'(vq[i].mk));
         chk("fl_recover_en", i, int'(fl_recover_en_o), int'(vq[i].rc));
         chk("rob_recover_en", i, int'(rob_recover_en_o), int'(vq[i].rc));
         if (vq[i].rc || vq[i].cd) begin
            chk("fl_recover_head", i, int'(fl_recover_head_o), int'(vq[i].hd));
            chk("rob_recover_tail", i, int'(rob_recover_tail_o), int'(vq[i].tl));
            chk("squash_mask", i, int'(squash_mask_o), int'(vq[i].sq));
         end
      end

      // stale resolves on an empty stack must leave state untouched
      @(negedge clk);
      drive(idle);
      br_resolve_en_i = 1'b1; br_resolve_tag_i = 2'd2;
      #1;
      chk("stale_ok_mask", 100, int'(br_mask_o), 0);
      @(negedge clk);
      br_resolve_tag_i = 2'd3; br_mispredict_i = 1'b1;
      #1;
      chk("stale_ok_after", 101, int'(br_mask_o), 0);
      @(negedge clk);
      drive(idle);
      #1;
      chk("stale_mp_no_pulse", 102, int'(fl_recover_en_o), 0);
      chk("stale_mp_no_stall", 103, int'(dispatch_stall_o), 0);
      chk("stale_tag", 104, int'(br_tag_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
